spike_event_logger: RTL and testbench

Downstream consumer of the integrate-and-fire neuron's `spike` output. It timestamps every spike against a free-running cycle counter and buffers the timestamps in a small FIFO, which a readout stage drains over a valid/ready handshake. It also reports a windowed spike-rate count. It is the bridge between the neuron core and the chip-level output pins / readout logic.

---
 rtl/spike_event_logger.sv | 92 +++++++++
 tb/tb_spike_event_logger.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// Timestamps neuron spikes against a free-running cycle counter and queues them
// in a small FIFO for readout; also reports a windowed spike-rate count.
module spike_event_logger #(
  parameter int TS_W     = 8,
  parameter int DEPTH    = 4,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                spike,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [TS_W-1:0]     evt_time,
  output logic [WIN_LOG2:0]   rate,
  output logic                rate_valid,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: an entry transfers at an edge where evt_valid and evt_ready are
  // both 1; evt_time is the head entry whenever evt_valid is 1.
  logic [TS_W-1:0]     ts_q;
  logic [TS_W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q;
  logic [WIN_LOG2-1:0] win_q;
  logic [WIN_LOG2:0]   acc_q, rate_q;
  logic                rate_valid_q, ovf_q;

  logic push_req, pop, full, push, drop;
  logic [WIN_LOG2:0] acc_sum;

  always_comb begin
    push_req = en & spike;
    pop      = (cnt_q != '0) & evt_ready;
    full     = (cnt_q == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    acc_sum  = acc_q + {{WIN_LOG2{1'b0}}, spike};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      win_q        <= '0;
      acc_q        <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= ts_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;

      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;

      rate_valid_q <= 1'b0;
      if (en) begin
        ts_q  <= ts_q + 1'b1;
        win_q <= win_q + 1'b1;
        if (&win_q) begin
          rate_q       <= acc_sum;
          rate_valid_q <= 1'b1;
          acc_q        <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign evt_valid  = (cnt_q != '0);
  assign evt_time   = mem_q[rd_q];
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Bench for spike_event_logger: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spike_event_logger;
  localparam int TS_W = 8;
  localparam int DEPTH = 4;
  localparam int WIN_LOG2 = 8;
  localparam int WIN_LEN = 1 << WIN_LOG2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, spike = 1'b0, evt_ready = 1'b0, clr_ovf = 1'b0;
  logic evt_valid, rate_valid, overflow;
  logic [TS_W-1:0] evt_time;
  logic [WIN_LOG2:0] rate;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;

  spike_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike(spike),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
    .rate(rate), .rate_valid(rate_valid), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- reference model ----
  logic [TS_W-1:0] exp_q[$];
  int m_ts = 0, m_win = 0, m_acc = 0, m_rate = 0;
  bit m_rv = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ts = 0; m_win = 0; m_acc = 0; m_rate = 0; m_rv = 1'b0; m_ovf = 1'b0;
    end else begin
      bit did_pop, dropped;
      did_pop = (exp_q.size() > 0) && evt_ready;
      dropped = 1'b0;
      if (did_pop) void'(exp_q.pop_front());
      if (en && spike) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ts[TS_W-1:0]);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_rv = 1'b0;
      if (en) begin
        m_acc += int'(spike);
        m_win += 1;
        if (m_win == WIN_LEN) begin
          m_rate = m_acc; m_rv = 1'b1; m_acc = 0; m_win = 0;
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
      end
    end
  end

  // ---- scoreboard compare, every cycle away from the active edge ----
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_evt_valid", int'(evt_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("model_evt_time", int'(evt_time), int'(exp_q[0]));
      check("model_rate", int'(rate), m_rate);
      check("model_rate_valid", int'(rate_valid), int'(m_rv));
      check("model_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---- driver ----
  task automatic step(input logic e, input logic s, input logic r, input logic c);
    en = e; spike = s; evt_ready = r; clr_ovf = c;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int drain_exp[3];
    @(negedge clk);
    do_reset(2);
    cmp_on = 1'b1;
    check("reset_evt_valid", int'(evt_valid), 0);
    check("reset_evt_time", int'(evt_time), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_rate", int'(rate), 0);

    // Spikes at enabled edges 3, 7, 10 with no readout.
    for (int i = 0; i <= 10; i++) step(1'b1, (i == 3 || i == 7 || i == 10), 1'b0, 1'b0);
    check("t1_valid", int'(evt_valid), 1);
    check("t1_head", int'(evt_time), 3);
    check("t1_ovf", int'(overflow), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_pop1_head", int'(evt_time), 7);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_pop2_head", int'(evt_time), 10);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_drained", int'(evt_valid), 0);

    // Five consecutive spikes from ts=0 into a 4-deep FIFO.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_ovf_set", int'(overflow), 1);
    check("t2_head", int'(evt_time), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_ovf_clr", int'(overflow), 0);
    check("t2_head_kept", int'(evt_time), 0);

    // Full FIFO, spike at ts=5 with a simultaneous pop.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_head", int'(evt_time), 1);
    check("t3_ovf", int'(overflow), 0);
    drain_exp = '{2, 3, 5};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("t3_drain", int'(evt_time), drain_exp[i]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_empty", int'(evt_valid), 0);

    // Rate window: alternating spikes, then solid spikes.
    do_reset(1);
    for (int i = 0; i < WIN_LEN; i++) step(1'b1, i[0], (i % 3) != 0, 1'b0);
    check("t4_rate_half", int'(rate), 128);
    check("t4_rate_pulse", int'(rate_valid), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_pulse_single", int'(rate_valid), 0);
    for (int i = 1; i < WIN_LEN; i++) step(1'b1, 1'b1, (i % 3) != 0, 1'b0);
    check("t4_rate_full", int'(rate), 256);
    check("t4_rate_pulse2", int'(rate_valid), 1);

    // en low with spike high: nothing moves.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_rate_held", int'(rate), 256);
    check("t5_no_push", int'(evt_valid), 0);

    // Walk ts up to 255 while draining, then spike at 255 and at the wrap.
    for (int i = 0; i < 255; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_ts255", int'(evt_time), 255);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_wrap_ovf", int'(overflow), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_wrap_head", int'(evt_time), 0);

    // Reset mid-stream with 3 entries and overflow set.
    do_reset(1);
    check("t6_valid", int'(evt_valid), 0);
    check("t6_time", int'(evt_time), 0);
    check("t6_ovf", int'(overflow), 0);
    check("t6_rate", int'(rate), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_first_stamp", int'(evt_time), 0);
    check("t6_first_valid", int'(evt_valid), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
